// File: rtl/mmss_time_counter.sv
// Minutes:seconds counter (00:00..59:59) with 1 Hz prescaler, start/stop, clear,
// load and up/down counting; outputs BCD digits for the seven-segment stage.
module mmss_time_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int PRE_W    = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic [2:0] ld_min_tens,
    input  logic [3:0] ld_min_ones,
    input  logic [2:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       count_down,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       wrap,
    output logic       done
);

    logic [PRE_W-1:0] prescaler;
    logic [2:0]       nxt_min_tens, nxt_sec_tens;
    logic [3:0]       nxt_min_ones, nxt_sec_ones;
    logic             nxt_wrap, nxt_done;
    logic             at_zero;

    assign at_zero = (min_tens == 3'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 3'd0) && (sec_ones == 4'd0);

    // Value the display moves to on the next one-second tick, with the
    // carry/borrow rippling from seconds-ones up to minutes-tens.
    always_comb begin
        nxt_min_tens = min_tens;
        nxt_min_ones = min_ones;
        nxt_sec_tens = sec_tens;
        nxt_sec_ones = sec_ones;
        nxt_wrap     = 1'b0;
        nxt_done     = 1'b0;
        if (!count_down) begin
            if (sec_ones != 4'd9) begin
                nxt_sec_ones = sec_ones + 4'd1;
            end else begin
                nxt_sec_ones = 4'd0;
                if (sec_tens != 3'd5) begin
                    nxt_sec_tens = sec_tens + 3'd1;
                end else begin
                    nxt_sec_tens = 3'd0;
                    if (min_ones != 4'd9) begin
                        nxt_min_ones = min_ones + 4'd1;
                    end else begin
                        nxt_min_ones = 4'd0;
                        if (min_tens != 3'd5) begin
                            nxt_min_tens = min_tens + 3'd1;
                        end else begin
                            nxt_min_tens = 3'd0;
                            nxt_wrap     = 1'b1;
                        end
                    end
                end
            end
        end else begin
            if (sec_ones != 4'd0) begin
                nxt_sec_ones = sec_ones - 4'd1;
            end else begin
                nxt_sec_ones = 4'd9;
                if (sec_tens != 3'd0) begin
                    nxt_sec_tens = sec_tens - 3'd1;
                end else begin
                    nxt_sec_tens = 3'd5;
                    if (min_ones != 4'd0) begin
                        nxt_min_ones = min_ones - 4'd1;
                    end else begin
                        nxt_min_ones = 4'd9;
                        nxt_min_tens = (min_tens != 3'd0) ? min_tens - 3'd1 : 3'd5;
                    end
                end
            end
            nxt_done = (nxt_min_tens == 3'd0) && (nxt_min_ones == 4'd0) &&
                       (nxt_sec_tens == 3'd0) && (nxt_sec_ones == 4'd0);
        end
    end

    // Control priority: rst > clear > load > start_stop > tick.
    always_ff @(posedge clk) begin
        wrap <= 1'b0;
        done <= 1'b0;
        if (rst) begin
            min_tens  <= 3'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 3'd0;
            sec_ones  <= 4'd0;
            running   <= 1'b0;
            prescaler <= '0;
        end else if (clear) begin
            min_tens  <= 3'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 3'd0;
            sec_ones  <= 4'd0;
            running   <= 1'b0;
            prescaler <= '0;
        end else if (load) begin
            min_tens  <= (ld_min_tens > 3'd5) ? 3'd0 : ld_min_tens;
            min_ones  <= (ld_min_ones > 4'd9) ? 4'd0 : ld_min_ones;
            sec_tens  <= (ld_sec_tens > 3'd5) ? 3'd0 : ld_sec_tens;
            sec_ones  <= (ld_sec_ones > 4'd9) ? 4'd0 : ld_sec_ones;
            running   <= 1'b0;
            prescaler <= '0;
        end else if (start_stop) begin
            // A down-count start from 00:00 would have nothing to count.
            if (running) begin
                running   <= 1'b0;
                prescaler <= '0;
            end else if (!(count_down && at_zero)) begin
                running   <= 1'b1;
                prescaler <= '0;
            end
        end else if (running) begin
            if (prescaler == PRE_W'(TICK_DIV - 1)) begin
                prescaler <= '0;
                min_tens  <= nxt_min_tens;
                min_ones  <= nxt_min_ones;
                sec_tens  <= nxt_sec_tens;
                sec_ones  <= nxt_sec_ones;
                wrap      <= nxt_wrap;
                done      <= nxt_done;
                if (nxt_done) begin
                    running <= 1'b0;
                end
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mmss_time_counter.sv
// Directed testbench for mmss_time_counter with TICK_DIV=4; each task checks one
// feature and expected displays are computed from minutes/seconds integers.
module tb_mmss_time_counter;

    logic       clk = 1'b0;
    logic       rst, start_stop, clear, load, count_down;
    logic [2:0] ld_min_tens, ld_sec_tens;
    logic [3:0] ld_min_ones, ld_sec_ones;
    logic [2:0] min_tens, sec_tens;
    logic [3:0] min_ones, sec_ones;
    logic       running, wrap, done;
    logic [13:0] disp;

    int tests  = 0;
    int failed = 0;

    mmss_time_counter #(.TICK_DIV(4), .PRE_W(3)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .load(load),
        .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones),
        .ld_sec_tens(ld_sec_tens), .ld_sec_ones(ld_sec_ones),
        .count_down(count_down),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    function automatic logic [13:0] mmss(input int m, input int s);
        logic [2:0] mt, st;
        logic [3:0] mo, so;
        mt = 3'(m / 10);
        mo = 4'(m % 10);
        st = 3'(s / 10);
        so = 4'(s % 10);
        return {mt, mo, st, so};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    task automatic do_start();
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] mt, input logic [3:0] mo,
                           input logic [2:0] st, input logic [3:0] so);
        ld_min_tens = mt;
        ld_min_ones = mo;
        ld_sec_tens = st;
        ld_sec_ones = so;
        load = 1'b1;
        cycles(1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(1);
        tests++;
        if ({disp, running, wrap, done} !== 17'd0) begin
            $display("[TB] FAIL reset_initial: got disp=%h run=%b wrap=%b done=%b, want all 0",
                     disp, running, wrap, done);
            failed++;
        end
        rst = 1'b0;
        count_down = 1'b0;
        do_start();
        cycles(9);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        tests++;
        if ({disp, running, wrap, done} !== 17'd0) begin
            $display("[TB] FAIL reset_midcount: got disp=%h run=%b wrap=%b done=%b, want all 0",
                     disp, running, wrap, done);
            failed++;
        end
        cycles(6);
        tests++;
        if (disp !== 14'd0 || running !== 1'b0) begin
            $display("[TB] FAIL reset_stays_stopped: got disp=%h run=%b, want 0/0", disp, running);
            failed++;
        end
    endtask

    task automatic test_up_count();
        do_clear();
        count_down = 1'b0;
        do_start();
        cycles(3);
        tests++;
        if (sec_ones !== 4'd0) begin
            $display("[TB] FAIL up_before_tick: got sec_ones=%0d, want 0", sec_ones);
            failed++;
        end
        cycles(1);
        tests++;
        if (sec_ones !== 4'd1 || running !== 1'b1) begin
            $display("[TB] FAIL up_tick1: got sec_ones=%0d run=%b, want 1/1", sec_ones, running);
            failed++;
        end
        cycles(4);
        tests++;
        if (sec_ones !== 4'd2) begin
            $display("[TB] FAIL up_tick2: got sec_ones=%0d, want 2", sec_ones);
            failed++;
        end
        cycles(32);
        tests++;
        if (disp !== mmss(0, 10) || wrap !== 1'b0) begin
            $display("[TB] FAIL up_tick10: got disp=%h wrap=%b, want %h/0", disp, wrap, mmss(0, 10));
            failed++;
        end
        do_start();
        tests++;
        if (running !== 1'b0) begin
            $display("[TB] FAIL up_stop: got run=%b, want 0", running);
            failed++;
        end
    endtask

    task automatic test_wrap();
        do_load(3'd5, 4'd9, 3'd5, 4'd8);
        count_down = 1'b0;
        do_start();
        cycles(4);
        tests++;
        if (disp !== mmss(59, 59) || wrap !== 1'b0) begin
            $display("[TB] FAIL wrap_5959: got disp=%h wrap=%b, want %h/0", disp, wrap, mmss(59, 59));
            failed++;
        end
        cycles(3);
        tests++;
        if (wrap !== 1'b0) begin
            $display("[TB] FAIL wrap_early: got wrap=%b, want 0", wrap);
            failed++;
        end
        cycles(1);
        tests++;
        if (disp !== 14'd0 || wrap !== 1'b1 || running !== 1'b1 || done !== 1'b0) begin
            $display("[TB] FAIL wrap_pulse: got disp=%h wrap=%b run=%b done=%b, want 0000/1/1/0",
                     disp, wrap, running, done);
            failed++;
        end
        cycles(1);
        tests++;
        if (wrap !== 1'b0 || disp !== 14'd0) begin
            $display("[TB] FAIL wrap_one_cycle: got wrap=%b disp=%h, want 0/0", wrap, disp);
            failed++;
        end
        do_start();
    endtask

    task automatic test_down_count();
        do_load(3'd0, 4'd1, 3'd0, 4'd0);
        count_down = 1'b1;
        do_start();
        cycles(4);
        tests++;
        if (disp !== mmss(0, 59) || running !== 1'b1) begin
            $display("[TB] FAIL down_tick1: got disp=%h run=%b, want %h/1", disp, running, mmss(0, 59));
            failed++;
        end
        cycles(58 * 4);
        tests++;
        if (disp !== mmss(0, 1) || done !== 1'b0 || running !== 1'b1) begin
            $display("[TB] FAIL down_tick59: got disp=%h done=%b run=%b, want %h/0/1",
                     disp, done, running, mmss(0, 1));
            failed++;
        end
        cycles(4);
        tests++;
        if (disp !== 14'd0 || done !== 1'b1 || running !== 1'b0 || wrap !== 1'b0) begin
            $display("[TB] FAIL down_done: got disp=%h done=%b run=%b wrap=%b, want 0000/1/0/0",
                     disp, done, running, wrap);
            failed++;
        end
        cycles(1);
        tests++;
        if (done !== 1'b0) begin
            $display("[TB] FAIL down_done_one_cycle: got done=%b, want 0", done);
            failed++;
        end
        cycles(12);
        tests++;
        if (disp !== 14'd0 || running !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL down_hold: got disp=%h run=%b done=%b, want 0/0/0", disp, running, done);
            failed++;
        end
    endtask

    task automatic test_pause_resume();
        do_clear();
        count_down = 1'b0;
        do_start();
        cycles(2);
        do_start();
        tests++;
        if (running !== 1'b0) begin
            $display("[TB] FAIL pause_stop: got run=%b, want 0", running);
            failed++;
        end
        cycles(20);
        tests++;
        if (disp !== 14'd0) begin
            $display("[TB] FAIL pause_hold: got disp=%h, want 0000", disp);
            failed++;
        end
        do_start();
        cycles(3);
        tests++;
        if (sec_ones !== 4'd0) begin
            $display("[TB] FAIL resume_early: got sec_ones=%0d, want 0", sec_ones);
            failed++;
        end
        cycles(1);
        tests++;
        if (sec_ones !== 4'd1) begin
            $display("[TB] FAIL resume_tick: got sec_ones=%0d, want 1", sec_ones);
            failed++;
        end
        do_start();
    endtask

    task automatic test_priority_load();
        do_load(3'd1, 4'd2, 3'd3, 4'd4);
        ld_min_tens = 3'd2;
        ld_min_ones = 4'd2;
        ld_sec_tens = 3'd2;
        ld_sec_ones = 4'd2;
        clear = 1'b1;
        load = 1'b1;
        start_stop = 1'b1;
        cycles(1);
        clear = 1'b0;
        load = 1'b0;
        start_stop = 1'b0;
        tests++;
        if (disp !== 14'd0 || running !== 1'b0) begin
            $display("[TB] FAIL prio_clear: got disp=%h run=%b, want 0000/0", disp, running);
            failed++;
        end
        ld_min_tens = 3'd0;
        ld_min_ones = 4'd3;
        ld_sec_tens = 3'd0;
        ld_sec_ones = 4'd3;
        load = 1'b1;
        start_stop = 1'b1;
        cycles(1);
        load = 1'b0;
        start_stop = 1'b0;
        tests++;
        if (disp !== mmss(3, 3) || running !== 1'b0) begin
            $display("[TB] FAIL prio_load: got disp=%h run=%b, want %h/0", disp, running, mmss(3, 3));
            failed++;
        end
        do_load(3'd6, 4'd3, 3'd3, 4'd12);
        tests++;
        if (disp !== mmss(3, 30)) begin
            $display("[TB] FAIL invalid_load: got disp=%h, want %h", disp, mmss(3, 30));
            failed++;
        end
        do_load(3'd2, 4'd15, 3'd7, 4'd5);
        tests++;
        if (disp !== mmss(20, 5)) begin
            $display("[TB] FAIL invalid_load2: got disp=%h, want %h", disp, mmss(20, 5));
            failed++;
        end
    endtask

    task automatic test_down_start_zero();
        do_clear();
        count_down = 1'b1;
        do_start();
        tests++;
        if (running !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL down_zero_start: got run=%b done=%b, want 0/0", running, done);
            failed++;
        end
        cycles(8);
        tests++;
        if (disp !== 14'd0 || running !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL down_zero_hold: got disp=%h run=%b done=%b, want 0/0/0",
                     disp, running, done);
            failed++;
        end
    endtask

    task automatic test_mode_change();
        do_load(3'd0, 4'd0, 3'd0, 4'd5);
        count_down = 1'b0;
        do_start();
        cycles(4);
        tests++;
        if (disp !== mmss(0, 6)) begin
            $display("[TB] FAIL mode_up: got disp=%h, want %h", disp, mmss(0, 6));
            failed++;
        end
        count_down = 1'b1;
        cycles(4);
        tests++;
        if (disp !== mmss(0, 5) || running !== 1'b1) begin
            $display("[TB] FAIL mode_down: got disp=%h run=%b, want %h/1", disp, running, mmss(0, 5));
            failed++;
        end
        do_start();
    endtask

    initial begin
        rst = 1'b1;
        start_stop = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        count_down = 1'b0;
        ld_min_tens = 3'd0;
        ld_min_ones = 4'd0;
        ld_sec_tens = 3'd0;
        ld_sec_ones = 4'd0;
        #1;
        test_reset();
        test_up_count();
        test_wrap();
        test_down_count();
        test_pause_resume();
        test_priority_load();
        test_down_start_zero();
        test_mode_change();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
